// File: rtl/sram_input_db_ctrl.sv
// Ping-pong controller for a 2-bank sky130 1rw1r input buffer: port 0 fills one bank, port 1 reads the other.
// Optional sticky protocol-error output `err` is enabled by defining SRAM_DB_CTRL_CHECK_EN.
module sram_input_db_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int BANK_WORDS = 2048
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    rd_avail,
  output logic [ADDR_WIDTH-1:0]   rd_count,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-2:0]   rd_addr,
  input  logic                    rd_release,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_data_valid,
  output logic                    sram_csb0,
  output logic                    sram_web0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [DATA_WIDTH-1:0]   sram_din0,
  output logic                    sram_csb1,
  output logic [ADDR_WIDTH-1:0]   sram_addr1,
`ifdef SRAM_DB_CTRL_CHECK_EN
  output logic                    err,
`endif
  input  logic [DATA_WIDTH-1:0]   sram_dout1
);

  localparam int PW = ADDR_WIDTH - 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(BANK_WORDS - 1);

  logic                  full_all [2];
  logic [ADDR_WIDTH-1:0] cnt_all  [2];

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          rd_pend_q, rd_pend_d;

  logic wr_acc;
  logic seal;
  logic release_acc;
  logic rd_acc;

  assign in_ready      = !rst && !full_all[wr_bank_q];
  assign rd_avail      = full_all[rd_bank_q];
  assign rd_count      = cnt_all[rd_bank_q];
  assign rd_data       = sram_dout1;
  assign rd_data_valid = rd_pend_q;

  always_comb begin
    wr_acc      = in_valid && in_ready;
    seal        = wr_acc && (in_last || (wr_ptr_q == LAST_PTR));
    release_acc = rd_release && rd_avail;
    // Out-of-range and not-yet-sealed reads never touch the macro.
    rd_acc      = rd_req && rd_avail && ({1'b0, rd_addr} < rd_count);
  end

  always_comb begin
    sram_csb0  = !wr_acc;
    sram_web0  = !wr_acc;
    sram_addr0 = wr_acc ? {wr_bank_q, wr_ptr_q} : '0;
    sram_din0  = wr_acc ? in_data : '0;
    sram_csb1  = !rd_acc;
    sram_addr1 = rd_acc ? {rd_bank_q, rd_addr} : '0;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = seal ? '0 : wr_ptr_q + PW'(1);
    end
    wr_bank_d = wr_bank_q ^ seal;
    rd_bank_d = rd_bank_q ^ release_acc;
    rd_pend_d = rd_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Seal and release in one cycle always hit different banks, so both may apply.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic                  full_q, full_d;
      logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

      always_comb begin
        full_d = full_q;
        cnt_d  = cnt_q;
        if (release_acc && (rd_bank_q == 1'(gi))) begin
          full_d = 1'b0;
        end
        if (seal && (wr_bank_q == 1'(gi))) begin
          full_d = 1'b1;
          cnt_d  = {1'b0, wr_ptr_q} + ADDR_WIDTH'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          full_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          full_q <= full_d;
          cnt_q  <= cnt_d;
        end
      end

      assign full_all[gi] = full_q;
      assign cnt_all[gi]  = cnt_q;
    end
  endgenerate

`ifdef SRAM_DB_CTRL_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (rd_req && !rd_acc) | (rd_release && !rd_avail);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_sram_input_db_ctrl.sv
// Directed bench for sram_input_db_ctrl with a behavioural 1rw1r SRAM model.
module tb_sram_input_db_ctrl;

  localparam int DW = 128;
  localparam int AW = 12;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          rd_avail;
  logic [AW-1:0] rd_count;
  logic          rd_req;
  logic [AW-2:0] rd_addr;
  logic          rd_release;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          sram_csb0;
  logic          sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1;
`ifdef SRAM_DB_CTRL_CHECK_EN
  logic          err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  sram_input_db_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_WORDS(2048)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .rd_avail      (rd_avail),
    .rd_count      (rd_count),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_release    (rd_release),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .sram_csb0     (sram_csb0),
    .sram_web0     (sram_web0),
    .sram_addr0    (sram_addr0),
    .sram_din0     (sram_din0),
    .sram_csb1     (sram_csb1),
    .sram_addr1    (sram_addr1),
`ifdef SRAM_DB_CTRL_CHECK_EN
    .err           (err),
`endif
    .sram_dout1    (sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural macro: both ports register on posedge, read data one cycle later.
  logic [DW-1:0] mem [4096];
  always @(posedge clk) begin
    if (!sram_csb0 && !sram_web0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    rd_req = 1'b0; rd_addr = '0; rd_release = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rd_avail", rd_avail, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_rd_valid", rd_data_valid, 0);
    chk("rst_csb0", sram_csb0, 1);
    chk("rst_web0", sram_web0, 1);
    chk("rst_csb1", sram_csb1, 1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Fill bank 0 completely with 0..2047, no in_last.
    for (int i = 0; i < 2048; i++) begin
      in_valid = 1'b1; in_data = DW'(i); in_last = 1'b0;
      #1;
      if (i == 0) begin
        chk("fill_csb0", sram_csb0, 0);
        chk("fill_web0", sram_web0, 0);
        chk("fill_addr0_first", sram_addr0, 0);
      end
      if (i == 2047) begin
        chk("fill_addr0_last", sram_addr0, 2047);
        chk("fill_din0_last", sram_din0, 2047);
        chk("fill_avail_before_seal", rd_avail, 0);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("full_rd_avail", rd_avail, 1);
    chk("full_rd_count", rd_count, 2048);
    chk("full_in_ready", in_ready, 1);
    chk("idle_csb0", sram_csb0, 1);

    // Back-to-back reads of 0, 1, 2047.
    rd_req = 1'b1; rd_addr = 0;
    #1;
    chk("rd0_csb1", sram_csb1, 0);
    chk("rd0_addr1", sram_addr1, 0);
    tick();
    rd_addr = 1;
    #1;
    chk("rd0_valid", rd_data_valid, 1);
    chk("rd0_data", rd_data, 0);
    chk("rd1_addr1", sram_addr1, 1);
    tick();
    rd_addr = 2047;
    #1;
    chk("rd1_valid", rd_data_valid, 1);
    chk("rd1_data", rd_data, 1);
    chk("rd2047_addr1", sram_addr1, 2047);
    tick();
    rd_req = 1'b0;
    #1;
    chk("rd2047_valid", rd_data_valid, 1);
    chk("rd2047_data", rd_data, 2047);
    chk("rd_idle_csb1", sram_csb1, 1);
    tick();
    #1;
    chk("rd_done_valid", rd_data_valid, 0);

    // Release bank 0, then an illegal read while nothing is readable.
    rd_release = 1'b1;
    #1;
    tick();
    rd_release = 1'b0; rd_req = 1'b1; rd_addr = 0;
    #1;
    chk("rel_rd_avail", rd_avail, 0);
    chk("noavail_csb1", sram_csb1, 1);
    tick();
    rd_req = 1'b0;
    #1;
    chk("noavail_valid", rd_data_valid, 0);
`ifdef SRAM_DB_CTRL_CHECK_EN
    chk("noavail_err", err, 1);
`endif

    // Restart: reset pulse.
    rst = 1'b1;
    #1;
    chk("rst2_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_in_ready_hi", in_ready, 1);
`ifdef SRAM_DB_CTRL_CHECK_EN
    chk("rst2_err", err, 0);
`endif

    // Bank 0: 10 words (last on 9); bank 1: 5 words (last on 4).
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = DW'(256 + i); in_last = (i == 9);
      #1;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(512 + i); in_last = (i == 4);
      #1;
      if (i == 0) chk("b1_addr0_first", sram_addr0, 2048);
      tick();
    end
    in_valid = 1'b1; in_data = DW'(57005); in_last = 1'b0;
    rd_req = 1'b1; rd_addr = 10;
    #1;
    chk("both_full_in_ready", in_ready, 0);
    chk("both_full_csb0", sram_csb0, 1);
    chk("both_full_rd_count", rd_count, 10);
    chk("oob_csb1", sram_csb1, 1);
    tick();
    in_valid = 1'b0; rd_req = 1'b0;
    #1;
    chk("oob_valid", rd_data_valid, 0);
`ifdef SRAM_DB_CTRL_CHECK_EN
    chk("oob_err", err, 1);
`endif

    // Read burst 0..9 on consecutive cycles.
    for (int j = 0; j < 10; j++) begin
      rd_req = 1'b1; rd_addr = 11'(j);
      #1;
      chk("burst_csb1", sram_csb1, 0);
      if (j == 0) begin
        chk("burst_valid_first", rd_data_valid, 0);
      end else begin
        chk("burst_valid", rd_data_valid, 1);
        chk("burst_data", rd_data, DW'(256 + j - 1));
      end
      tick();
    end

    // Read of word 9 together with release: data still returned from old bank.
    rd_req = 1'b1; rd_addr = 9; rd_release = 1'b1;
    #1;
    chk("burst_last_valid", rd_data_valid, 1);
    chk("burst_last_data", rd_data, 265);
    chk("relrd_addr1", sram_addr1, 9);
    tick();
    rd_req = 1'b0; rd_release = 1'b0;
    #1;
    chk("relrd_valid", rd_data_valid, 1);
    chk("relrd_data", rd_data, 265);
    chk("rel_rd_count", rd_count, 5);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_rd_avail2", rd_avail, 1);

    // Bank 0: 3 words, then release bank 1.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = DW'(768 + i); in_last = (i == 2);
      #1;
      if (i == 0) chk("b0_refill_addr0", sram_addr0, 0);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    chk("refill_in_ready", in_ready, 0);
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    #1;
    chk("rel3_rd_avail", rd_avail, 1);
    chk("rel3_rd_count", rd_count, 3);
    chk("rel3_in_ready", in_ready, 1);

    // Seal bank 1 in the same cycle bank 0 is released.
    in_valid = 1'b1; in_data = DW'(1024); in_last = 1'b0;
    #1;
    chk("b1w0_addr0", sram_addr0, 2048);
    tick();
    in_data = DW'(1025); in_last = 1'b1; rd_release = 1'b1;
    #1;
    chk("b1w1_csb0", sram_csb0, 0);
    tick();
    in_valid = 1'b0; in_last = 1'b0; rd_release = 1'b0;
    #1;
    chk("swap_rd_avail", rd_avail, 1);
    chk("swap_rd_count", rd_count, 2);
    chk("swap_in_ready", in_ready, 1);
    rd_req = 1'b1; rd_addr = 1;
    #1;
    chk("swap_rd_addr1", sram_addr1, 2049);
    tick();
    rd_req = 1'b0;
    #1;
    chk("swap_rd_valid", rd_data_valid, 1);
    chk("swap_rd_data", rd_data, 1025);

    // 7 words into bank 0, read in flight, then reset mid-cycle.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = DW'(1280 + i); in_last = 1'b0;
      if (i == 6) begin
        rd_req = 1'b1; rd_addr = 0;
      end
      #1;
      tick();
    end
    rd_req = 1'b0; in_data = DW'(1287);
    #1;
    chk("pre_rst_valid", rd_data_valid, 1);
    chk("pre_rst_data", rd_data, 1024);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_rd_avail", rd_avail, 0);
    chk("mid_rst_csb0", sram_csb0, 1);
    chk("mid_rst_valid", rd_data_valid, 0);
    chk("mid_rst_rd_count", rd_count, 0);
    tick();
    rst = 1'b0; in_data = DW'(1536);
    #1;
    chk("post_rst_csb0", sram_csb0, 0);
    chk("post_rst_addr0", sram_addr0, 0);
    chk("post_rst_din0", sram_din0, 1536);
    tick();
    in_valid = 1'b0;
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
